rvs192_branch_resolver: RTL and testbench

Branch resolution and PC-redirect unit for the RVS192 execute stage. It takes the `ge`/`eq` flags and `target_pc` computed by the EX-stage ALU for each control-transfer instruction and decides the actual direction and target. On a misprediction it issues a registered, handshaked redirect to fetch, flushes the front end, and then blocks new resolutions while wrong-path instructions drain. Every resolved branch produces a one-cycle predictor-update record.

---
 rtl/rvs192_branch_resolver_pkg.sv | 28 ++
 rtl/rvs192_branch_resolver_decide.sv | 45 ++++
 rtl/rvs192_branch_resolver.sv | 131 +++++++++++++
 tb/tb_rvs192_branch_resolver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvs192_branch_resolver_pkg.sv
// Shared types and defaults for the RVS192 branch resolver.
package rvs192_branch_resolver_pkg;

  localparam int unsigned DATA_LENGTH_DEF  = 32;
  localparam int unsigned DRAIN_CYCLES_DEF = 2;
  localparam int unsigned BR_KIND_W        = 4;

  typedef enum logic [BR_KIND_W-1:0] {
    BR_BEQ  = 4'd0,
    BR_BNE  = 4'd1,
    BR_BLT  = 4'd2,
    BR_BGE  = 4'd3,
    BR_BLTU = 4'd4,
    BR_BGEU = 4'd5,
    BR_JAL  = 4'd6,
    BR_JALR = 4'd7
  } br_kind_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
    ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_type;

  function automatic logic is_jump(input br_kind_t kind);
    return (kind == BR_JAL) || (kind == BR_JALR);
  endfunction

endpackage

// File: rtl/rvs192_branch_resolver_decide.sv
// Combinational branch decision: direction, correct next PC, mispredict and misalign.
module rvs192_br_decide
  import rvs192_branch_resolver_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEF
) (
  input  br_kind_t               br_kind,
  input  logic                   ge,
  input  logic                   eq,
  input  logic [DATA_LENGTH-1:0] target_pc,
  input  logic [DATA_LENGTH-1:0] pc_ex,
  input  logic                   pred_taken,
  input  logic [DATA_LENGTH-1:0] pred_target,
  output logic                   taken_c,
  output logic [DATA_LENGTH-1:0] act_target_c,
  output logic                   mispredict_c,
  output logic                   misalign_c
);

  always_comb begin
    taken_c = 1'b0;
    unique case (br_kind)
      BR_BEQ:           taken_c = eq;
      BR_BNE:           taken_c = !eq;
      BR_BLT, BR_BLTU:  taken_c = !ge;
      BR_BGE, BR_BGEU:  taken_c = ge;
      BR_JAL, BR_JALR:  taken_c = 1'b1;
      default:          taken_c = 1'b0;
    endcase
  end

  // act_target_c is the architecturally correct next PC, taken or not.
  always_comb begin
    act_target_c = pc_ex + DATA_LENGTH'(4);
    if (taken_c) begin
      if (br_kind == BR_JALR) act_target_c = target_pc & ~DATA_LENGTH'(1);
      else                    act_target_c = target_pc;
    end
  end

  assign misalign_c   = taken_c && act_target_c[1];
  assign mispredict_c = (taken_c != pred_taken) ||
                        (taken_c && pred_taken && (act_target_c != pred_target));

endmodule

// File: rtl/rvs192_branch_resolver.sv
// Branch resolution and PC-redirect unit for the RVS192 execute stage.
// Optional perf counters enabled by defining RVS192_BRU_PERF_EN.
module rvs192_branch_resolver
  import rvs192_branch_resolver_pkg::*;
#(
  parameter int unsigned DATA_LENGTH  = DATA_LENGTH_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  output logic                   br_ready,
  input  br_kind_t               br_kind,
  input  logic                   ge,
  input  logic                   eq,
  input  logic [DATA_LENGTH-1:0] target_pc,
  input  logic [DATA_LENGTH-1:0] pc_ex,
  input  logic                   pred_taken,
  input  logic [DATA_LENGTH-1:0] pred_target,
  output logic                   redirect_valid,
  output logic [DATA_LENGTH-1:0] redirect_pc,
  input  logic                   redirect_ready,
  output logic                   flush_front,
  output logic                   upd_valid,
  output logic [DATA_LENGTH-1:0] upd_pc,
  output logic                   upd_taken,
  output logic [DATA_LENGTH-1:0] upd_target,
  output logic                   misalign
`ifdef RVS192_BRU_PERF_EN
  ,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
`endif
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     drain_cnt;
  logic                 accept_c;
  logic                 enter_redirect_c;
  logic                 taken_c;
  logic [DATA_LENGTH-1:0] act_target_c;
  logic                 mispredict_c;
  logic                 misalign_c;

  rvs192_br_decide #(.DATA_LENGTH(DATA_LENGTH)) u_decide (
    .br_kind      (br_kind),
    .ge           (ge),
    .eq           (eq),
    .target_pc    (target_pc),
    .pc_ex        (pc_ex),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .taken_c      (taken_c),
    .act_target_c (act_target_c),
    .mispredict_c (mispredict_c),
    .misalign_c   (misalign_c)
  );

  // br_ready is a pure decode of the state register.
  assign br_ready         = (state == IDLE);
  assign accept_c         = br_valid && br_ready;
  assign enter_redirect_c = accept_c && mispredict_c && !misalign_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_front    <= 1'b0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      misalign       <= 1'b0;
    end else begin
      upd_valid   <= accept_c;
      misalign    <= accept_c && misalign_c;
      flush_front <= 1'b0;
      if (accept_c) begin
        upd_pc     <= pc_ex;
        upd_taken  <= taken_c;
        upd_target <= act_target_c;
      end
      case (state)
        IDLE: begin
          if (enter_redirect_c) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= act_target_c;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush_front    <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state     <= DRAIN;
              drain_cnt <= CNT_W'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          // Wrong-path instructions are still in flight; br_valid is ignored.
          if (drain_cnt <= CNT_W'(1)) state <= IDLE;
          else                        drain_cnt <= drain_cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RVS192_BRU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (accept_c)         perf_branches    <= perf_branches + 32'd1;
      if (enter_redirect_c) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvs192_branch_resolver.sv
// Randomized self-checking bench for rvs192_branch_resolver with a cycle-level reference model.
module tb_rvs192_branch_resolver;
  import rvs192_branch_resolver_pkg::*;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  br_kind_t    br_kind;
  logic        ge, eq;
  logic [31:0] target_pc, pc_ex, pred_target;
  logic        pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush_front;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        misalign;
`ifdef RVS192_BRU_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edge index, pending redirect, last handshake edge.
  int          cyc    = 0;
  bit          pend   = 0;
  logic [31:0] pend_pc = '0;
  int          hs_cyc = -1000;
  logic [31:0] m_pb = '0, m_pm = '0;

  rvs192_branch_resolver #(.DATA_LENGTH(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_kind(br_kind), .ge(ge), .eq(eq), .target_pc(target_pc), .pc_ex(pc_ex),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush_front(flush_front),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .misalign(misalign)
`ifdef RVS192_BRU_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic resolve(input br_kind_t k, input logic g, input logic e,
                         input logic [31:0] t, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptg,
                         output logic tk, output logic [31:0] at,
                         output logic mp, output logic ma);
    case (k)
      BR_BEQ:          tk = e;
      BR_BNE:          tk = !e;
      BR_BLT, BR_BLTU: tk = !g;
      BR_BGE, BR_BGEU: tk = g;
      default:         tk = 1'b1;
    endcase
    if (!tk)               at = pc + 32'd4;
    else if (k == BR_JALR) at = {t[31:1], 1'b0};
    else                   at = t;
    ma = tk && at[1];
    mp = (tk != pt) || (tk && pt && (at != ptg));
  endtask

  // Advance one clock, update the model and compare every observable output.
  task automatic step();
    logic        tk, mp, ma;
    logic [31:0] at;
    bit          rdy, hs, acc;
    resolve(br_kind, ge, eq, target_pc, pc_ex, pred_taken, pred_target, tk, at, mp, ma);
    rdy = !pend && (cyc - hs_cyc >= DRAIN + 1);
    hs  = pend && redirect_ready;
    acc = br_valid && rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      pend = 0; pend_pc = '0; hs_cyc = -1000; m_pb = '0; m_pm = '0;
      check("rst_br_ready", br_ready, 1);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_flush", flush_front, 0);
      check("rst_upd_valid", upd_valid, 0);
      check("rst_upd_pc", upd_pc, 0);
      check("rst_upd_taken", upd_taken, 0);
      check("rst_upd_target", upd_target, 0);
      check("rst_misalign", misalign, 0);
`ifdef RVS192_BRU_PERF_EN
      check("rst_perf_branches", perf_branches, 0);
      check("rst_perf_mispredicts", perf_mispredicts, 0);
`endif
      return;
    end
    if (hs) begin
      pend   = 0;
      hs_cyc = cyc - 1;
    end
    if (acc) begin
      m_pb = m_pb + 32'd1;
      if (mp && !ma) begin
        pend    = 1;
        pend_pc = at;
        m_pm    = m_pm + 32'd1;
      end
    end
    check("br_ready", br_ready, (!pend && (cyc - hs_cyc >= DRAIN + 1)) ? 1 : 0);
    check("redirect_valid", redirect_valid, pend ? 1 : 0);
    if (pend) check("redirect_pc", redirect_pc, pend_pc);
    check("flush_front", flush_front, hs ? 1 : 0);
    check("upd_valid", upd_valid, acc ? 1 : 0);
    check("misalign", misalign, (acc && ma) ? 1 : 0);
    if (acc) begin
      check("upd_pc", upd_pc, pc_ex);
      check("upd_taken", upd_taken, tk);
      check("upd_target", upd_target, at);
    end
`ifdef RVS192_BRU_PERF_EN
    check("perf_branches", perf_branches, m_pb);
    check("perf_mispredicts", perf_mispredicts, m_pm);
`endif
  endtask

  task automatic drive(input br_kind_t k, input logic g, input logic e,
                       input logic [31:0] t, input logic [31:0] pc,
                       input logic pt, input logic [31:0] ptg);
    br_valid = 1'b1; br_kind = k; ge = g; eq = e;
    target_pc = t; pc_ex = pc; pred_taken = pt; pred_target = ptg;
  endtask

  task automatic wait_ready();
    int n = 0;
    br_valid = 1'b0;
    redirect_ready = 1'b1;
    while (!br_ready && n < 20) begin
      step();
      n++;
    end
    check("wait_ready_timeout", br_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_kind = BR_BEQ; ge = 1'b0; eq = 1'b0;
    target_pc = '0; pc_ex = '0; pred_taken = 1'b0; pred_target = '0;
    redirect_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Correctly predicted taken BEQ.
    drive(BR_BEQ, 0, 1, 32'h140, 32'h100, 1, 32'h140);
    step();
    check("t1_upd_taken", upd_taken, 1);
    check("t1_upd_target", upd_target, 32'h140);
    check("t1_br_ready", br_ready, 1);
    br_valid = 1'b0;
    step();

    // BLTU not taken but predicted taken, redirect held off for 3 cycles.
    redirect_ready = 1'b0;
    drive(BR_BLTU, 1, 0, 32'h280, 32'h200, 1, 32'h280);
    step();
    br_valid = 1'b0;
    check("t2_redirect_pc", redirect_pc, 32'h204);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_redirect_pc_stable", redirect_pc, 32'h204);
    end
    redirect_ready = 1'b1;
    step();
    check("t2_flush", flush_front, 1);
    check("t2_br_ready_d0", br_ready, 0);
    redirect_ready = 1'b0;
    drive(BR_BEQ, 0, 1, 32'h500, 32'h400, 1, 32'h500);
    step();
    check("t2_br_ready_d1", br_ready, 0);
    check("t2_ignored_d1", upd_valid, 0);
    step();
    check("t2_br_ready_d2", br_ready, 1);
    check("t2_ignored_d2", upd_valid, 0);
    step();
    check("t2_accept_after_drain", upd_valid, 1);
    br_valid = 1'b0;

    // JALR clears bit 0 of the target; zero-wait handshake.
    redirect_ready = 1'b1;
    drive(BR_JALR, 0, 0, 32'h0000_1235, 32'h600, 1, 32'h1000);
    step();
    br_valid = 1'b0;
    check("t3_redirect_pc", redirect_pc, 32'h1234);
    check("t3_upd_target", upd_target, 32'h1234);
    wait_ready();

    // Misaligned JAL: pulse only, no redirect.
    drive(BR_JAL, 0, 0, 32'h302, 32'h300, 0, 32'h0);
    step();
    br_valid = 1'b0;
    check("t4_misalign", misalign, 1);
    check("t4_no_redirect", redirect_valid, 0);
    check("t4_upd_taken", upd_taken, 1);
    step();
    check("t4_no_flush", flush_front, 0);

    // Not-taken fall-through wraps to zero.
    drive(BR_BNE, 0, 1, 32'h50, 32'hFFFF_FFFC, 1, 32'h50);
    step();
    br_valid = 1'b0;
    check("t5_redirect_pc_wrap", redirect_pc, 32'h0);
    wait_ready();

    // Reset while a redirect is pending.
    redirect_ready = 1'b0;
    drive(BR_BEQ, 0, 0, 32'h700, 32'h680, 1, 32'h700);
    step();
    br_valid = 1'b0;
    check("t6_in_redirect", redirect_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    drive(BR_BEQ, 0, 1, 32'h800, 32'h7F0, 1, 32'h800);
    step();
    drive(BR_BNE, 0, 0, 32'h900, 32'h7F4, 1, 32'h900);
    step();
    drive(BR_BGE, 0, 0, 32'hA00, 32'h7F8, 1, 32'hA00);
    step();
    br_valid = 1'b0;
    step();
`ifdef RVS192_BRU_PERF_EN
    check("t6_perf_branches", perf_branches, 3);
    check("t6_perf_mispredicts", perf_mispredicts, 1);
`endif
    wait_ready();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        tk, mp, ma;
      logic [31:0] at, t, pc;
      br_kind_t    k;
      k  = br_kind_t'(4'($urandom_range(0, 7)));
      pc = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      t  = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, pc,
            1'($urandom_range(0, 1)), $urandom());
      br_valid = ($urandom_range(0, 9) < 8);
      redirect_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        resolve(br_kind, ge, eq, target_pc, pc_ex, pred_taken, pred_target, tk, at, mp, ma);
        pred_taken  = tk;
        pred_target = tk ? at : 32'($urandom());
      end
      step();
    end
    br_valid = 1'b0;
    wait_ready();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
